// File: rtl/sen_lut_arbiter_if.sv
// Bus bundle between the two table requesters, the arbiter and the sine ROM.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment: the two requesters plus the ROM read port.
interface sen_lut_arbiter_if #(
  parameter int WIDTH = 24,
  parameter int AW    = 9
);

  logic             req0;
  logic [AW-1:0]    addr0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata;
  logic             oob;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_rd;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;

  modport slave (
    input  req0, addr0, req1, addr1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, oob, mem_a, cnt0, cnt1
  );

  modport master (
    output req0, addr0, req1, addr1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, oob, mem_a, cnt0, cnt1
  );

endinterface

// File: rtl/sen_lut_arbiter.sv
// Two-requester round-robin arbiter in front of a combinational sine ROM.
// Each grant issues one ROM read. The read result, together with an
// out-of-range flag, is registered and returned one cycle later.
// The per-requester grant counters saturate at 16'hFFFF.
// Optional feature: define SEN_ARB_LOCK_EN to add the lock0/lock1 inputs.
// While a requester holds its lock input, the arbiter keeps granting
// that requester and ignores the other one.
module sen_lut_arbiter #(
  parameter int WIDTH  = 24,
  parameter int AMOUNT = 302,
  parameter int AW     = 9
) (
  input  logic clk,
  input  logic rst,
`ifdef SEN_ARB_LOCK_EN
  input  logic lock0,
  input  logic lock1,
`endif
  sen_lut_arbiter_if.slave bus
);

  // AMOUNT may equal 2**AW, so the range compare needs one extra bit.
  localparam logic [AW:0] AMOUNT_LIM = (AW + 1)'(AMOUNT);

`ifdef SEN_ARB_LOCK_EN
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ARB = 2'd0
  } state_t;
`endif

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             grant0, grant1;
  logic             rrGnt0, rrGnt1;
  logic [AW-1:0]    grantAddr;
  logic             oobNext;
  logic [WIDTH-1:0] rdata_q;
  logic             oob_q;
  logic             rvalid0_q, rvalid1_q;
  logic [15:0]      cnt0_q, cnt1_q;

  // Plain round-robin choice: a lone requester wins, and a tie goes to prio.
  assign rrGnt0 = bus.req0 && (!bus.req1 || !prio_q);
  assign rrGnt1 = bus.req1 && !rrGnt0;

  // Grant decision, next priority and next FSM state.
  // Reset forces the grants low so that nothing leaks onto the ROM bus.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    prio_d  = prio_q;
    state_d = state_q;
    if (!rst) begin
`ifdef SEN_ARB_LOCK_EN
      if (state_q == HOLD0 && bus.req0 && lock0) begin
        grant0 = 1'b1;
      end else if (state_q == HOLD1 && bus.req1 && lock1) begin
        grant1 = 1'b1;
      end else begin
        grant0 = rrGnt0;
        grant1 = rrGnt1;
        if (rrGnt0) begin
          prio_d = 1'b1;
        end else if (rrGnt1) begin
          prio_d = 1'b0;
        end
        if (rrGnt0 && lock0) begin
          state_d = HOLD0;
        end else if (rrGnt1 && lock1) begin
          state_d = HOLD1;
        end else begin
          state_d = ARB;
        end
      end
`else
      grant0 = rrGnt0;
      grant1 = rrGnt1;
      if (rrGnt0) begin
        prio_d = 1'b1;
      end else if (rrGnt1) begin
        prio_d = 1'b0;
      end
      state_d = ARB;
`endif
    end
  end

  assign grantAddr = grant0 ? bus.addr0 : bus.addr1;
  assign oobNext   = ({1'b0, grantAddr} >= AMOUNT_LIM);

  assign bus.gnt0    = grant0;
  assign bus.gnt1    = grant1;
  assign bus.mem_a   = (grant0 || grant1) ? {{(WIDTH - AW){1'b0}}, grantAddr} : '0;
  assign bus.rdata   = rdata_q;
  assign bus.oob     = oob_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.cnt0    = cnt0_q;
  assign bus.cnt1    = cnt1_q;

  // Arbitration state: the priority pointer and the lock FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q  <= 1'b0;
      state_q <= ARB;
    end else begin
      prio_q  <= prio_d;
      state_q <= state_d;
    end
  end

  // Read return path: capture the ROM word, or zero when out of range, on a grant.
  // The data holds when there is no grant, and rvalid pulses for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      oob_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= grant0;
      rvalid1_q <= grant1;
      if (grant0 || grant1) begin
        oob_q   <= oobNext;
        rdata_q <= oobNext ? '0 : bus.mem_rd;
      end
    end
  end

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && cnt0_q != 16'hFFFF) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (grant1 && cnt1_q != 16'hFFFF) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sen_lut_arbiter.sv
// Scoreboard bench for sen_lut_arbiter.
// Each stimulus cycle compares the grants against a round-robin reference model
// and pushes the expected read result into a queue.
// A monitor on the falling edge pops that queue whenever rvalid appears.
// Define SEN_ARB_LOCK_EN to build and exercise the lock feature as well.
module tb_sen_lut_arbiter;

  localparam int WIDTH  = 24;
  localparam int AMOUNT = 302;
  localparam int AW     = 9;

  typedef struct {
    int               who;
    logic [WIDTH-1:0] data;
    logic             oob;
    int               issue;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   prioM = 0;
  int   ownerM = -1;
  int   cntM0 = 0;
  int   cntM1 = 0;
  int   lastGntAct = -1;
  int   lastGntExp = -1;
  expT  q[$];
  expT  mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sen_lut_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

`ifdef SEN_ARB_LOCK_EN
  logic lock0 = 1'b0;
  logic lock1 = 1'b0;
  sen_lut_arbiter #(.WIDTH(WIDTH), .AMOUNT(AMOUNT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .lock0(lock0), .lock1(lock1), .bus(bus.slave)
  );
`else
  sen_lut_arbiter #(.WIDTH(WIDTH), .AMOUNT(AMOUNT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  // Sine ROM stand-in: word 5 is pinned to a known value, and the rest come from a hash.
  function automatic logic [WIDTH-1:0] romWord(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] w;
    if (a == 5) return 24'h00A1B2;
    w = a * 24'h009E37 + 24'h013579;
    return w;
  endfunction

  assign bus.mem_rd = romWord(bus.mem_a);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    checkOutput("rst_mem_a", bus.mem_a, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_oob", bus.oob, 0);
    checkOutput("rst_rvalid0", bus.rvalid0, 0);
    checkOutput("rst_rvalid1", bus.rvalid1, 0);
    checkOutput("rst_cnt0", bus.cnt0, 0);
    checkOutput("rst_cnt1", bus.cnt1, 0);
  endtask

  task automatic resetModel();
    q.delete();
    prioM  = 0;
    ownerM = -1;
    cntM0  = 0;
    cntM1  = 0;
  endtask

  // Hold reset with both requests raised; grants and mem_a must stay low throughout.
  task automatic resetDut();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 5;
    bus.req1 = 1'b1; bus.addr1 = 7;
    #1 checkResetValues();
    @(posedge clk); #1;
    checkResetValues();
    resetModel();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of requests, check the grants against the model, and queue the read.
  task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                               input logic r1, input logic [AW-1:0] a1,
                               input logic l0, input logic l1);
    int               g;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             o;
    @(posedge clk); #1;
    bus.req0 = r0; bus.addr0 = a0;
    bus.req1 = r1; bus.addr1 = a1;
`ifdef SEN_ARB_LOCK_EN
    lock0 = l0;
    lock1 = l1;
`endif
    #1;
    g = -1;
    if (ownerM == 0 && r0 && l0) g = 0;
    else if (ownerM == 1 && r1 && l1) g = 1;
    else begin
      if (r0 && r1) g = prioM;
      else if (r0) g = 0;
      else if (r1) g = 1;
      if (g >= 0) prioM = 1 - g;
`ifdef SEN_ARB_LOCK_EN
      ownerM = (g == 0 && l0) ? 0 : (g == 1 && l1) ? 1 : -1;
`else
      ownerM = -1;
`endif
    end
    lastGntExp = g;
    lastGntAct = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
    a = (g == 1) ? a1 : a0;
    checkOutput("gnt0", bus.gnt0, g == 0);
    checkOutput("gnt1", bus.gnt1, g == 1);
    checkOutput("mem_a", bus.mem_a, (g < 0) ? 0 : 32'(a));
    checkOutput("cnt0", bus.cnt0, cntM0);
    checkOutput("cnt1", bus.cnt1, cntM1);
    if (g >= 0) begin
      o = (int'(a) >= AMOUNT);
      d = o ? '0 : romWord(WIDTH'(a));
      q.push_back('{who: g, data: d, oob: o, issue: cyc});
      if (g == 0 && cntM0 < 65535) cntM0++;
      if (g == 1 && cntM1 < 65535) cntM1++;
    end
  endtask

  function automatic logic [AW-1:0] pickAddr();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return AW'(AMOUNT - 1);
      2:       return AW'(AMOUNT);
      3:       return '1;
      default: return AW'($urandom_range(0, (1 << AW) - 1));
    endcase
  endfunction

  // Monitor: each rvalid must match the oldest queued read, issued exactly one cycle earlier.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rvalid0 && bus.rvalid1) checkOutput("rvalid_both", 1, 0);
      if (bus.rvalid0 || bus.rvalid1) begin
        if (q.size() == 0) begin
          checkOutput("rvalid_unexpected", {bus.rvalid1, bus.rvalid0}, 0);
        end else begin
          mon = q.pop_front();
          checkOutput("rvalid_who", bus.rvalid1 ? 1 : 0, mon.who);
          checkOutput("rdata", bus.rdata, mon.data);
          checkOutput("oob", bus.oob, mon.oob);
          checkOutput("latency", cyc - mon.issue, 1);
        end
      end else if (q.size() > 0 && q[0].issue < cyc) begin
        checkOutput("rvalid_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          p0, p1, r0, r1, l0, l1;
    logic [AW-1:0] a0, a1;
    bus.req0 = 1'b0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0;
    resetDut();

    // Single request: same-cycle grant and ROM word 5 one cycle later.
    applyStimulus(1'b1, 9'd5, 1'b0, 9'd0, 1'b0, 1'b0);
    checkOutput("single_gnt0", lastGntAct, 0);
    applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    checkOutput("word5_rdata", bus.rdata, 24'h00A1B2);

    // Both requesters held for four cycles after reset: the grants alternate 0,1,0,1.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 9'd10, 1'b1, 9'd20, 1'b0, 1'b0);
      checkOutput("rr_order", lastGntAct, i % 2);
    end
    applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    checkOutput("rr_cnt0", bus.cnt0, 2);
    checkOutput("rr_cnt1", bus.cnt1, 2);

    // Out-of-range index: rdata reads as zero and oob is set.
    applyStimulus(1'b0, 9'd0, 1'b1, 9'd302, 1'b0, 1'b0);
    applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    checkOutput("oob_flag", bus.oob, 1);
    checkOutput("oob_rdata", bus.rdata, 0);

    // Reset pulsed during a grant cycle discards the pending read.
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.addr0 = 9'd33;
    #1 checkOutput("pre_reset_gnt0", bus.gnt0, 1);
    #1 rst = 1'b1;
    #1 checkResetValues();
    resetModel();
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);

`ifdef SEN_ARB_LOCK_EN
    // Lock0 held for three cycles keeps requester 0. Dropping it hands the grant to requester 1.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 9'd3, 1'b1, 9'd4, 1'b1, 1'b0);
      checkOutput("lock_gnt0", lastGntAct, 0);
    end
    applyStimulus(1'b1, 9'd3, 1'b1, 9'd4, 1'b0, 1'b0);
    checkOutput("unlock_gnt1", lastGntAct, 1);
`endif

    // Random traffic: each requester holds its request and address until it is granted.
    resetDut();
    p0 = 1'b0; p1 = 1'b0; r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!p0) begin
        r0 = ($urandom_range(0, 3) != 0);
        a0 = pickAddr();
      end
      if (!p1) begin
        r1 = ($urandom_range(0, 3) != 0);
        a1 = pickAddr();
      end
      l0 = ($urandom_range(0, 3) == 0);
      l1 = ($urandom_range(0, 3) == 0);
`ifndef SEN_ARB_LOCK_EN
      l0 = 1'b0;
      l1 = 1'b0;
`endif
      applyStimulus(r0, a0, r1, a1, l0, l1);
      p0 = r0 && (lastGntExp != 0);
      p1 = r1 && (lastGntExp != 1);
    end

    // Long run of requester-0 grants drives cnt0 into saturation.
    resetDut();
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, AW'($urandom_range(0, 400)), 1'b0, 9'd0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    checkOutput("cnt0_saturated", bus.cnt0, 16'hFFFF);
    checkOutput("cnt1_idle", bus.cnt1, 0);

    applyStimulus(1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sen_lut_arbiter.md
SEN_LUT_ARBITER -- requirements
Module: sen_lut_arbiter

Interface
REQ-001 Parameter WIDTH, default 24, is the sine-table word width and the ROM address-port width.
REQ-002 Parameter AMOUNT, default 302, is the number of valid table entries.
REQ-003 Parameter AW, default 9, is the requester address width; AW SHALL satisfy 2**AW >= AMOUNT.
REQ-004 Ports SHALL be as follows:
  clk      in   1      single clock; all state updates on rising edge
  rst      in   1      asynchronous, active-high reset
  req0     in   1      requester 0 access request
  addr0    in   AW     requester 0 table index
  req1     in   1      requester 1 access request
  addr1    in   AW     requester 1 table index
  gnt0     out  1      requester 0 granted this cycle
  gnt1     out  1      requester 1 granted this cycle
  rvalid0  out  1      rdata valid for requester 0
  rvalid1  out  1      rdata valid for requester 1
  rdata    out  WIDTH  registered table word
  oob      out  1      registered out-of-range flag, qualifies rdata
  mem_a    out  WIDTH  address to sine ROM (combinational read)
  mem_rd   in   WIDTH  word returned by sine ROM
  cnt0     out  16     saturating grant count, requester 0
  cnt1     out  16     saturating grant count, requester 1

Function
REQ-005 At most one of gnt0/gnt1 SHALL be high in any cycle; grants are combinational from req0, req1, and internal state.
REQ-006 With a single request active, that requester SHALL be granted in the same cycle.
REQ-007 With both requests active, the requester indicated by the 1-bit priority pointer prio SHALL be granted, where prio=0 selects requester 0.
REQ-008 After every grant, prio SHALL point to the non-granted requester (round-robin); with no grant, prio SHALL hold.
REQ-009 mem_a SHALL be the granted address zero-extended to WIDTH, and SHALL be 0 when no grant is issued.
REQ-010 A requester SHALL hold req and addr stable until it sees its gnt; it SHALL deassert req in the cycle after gnt unless it is issuing a new access.
REQ-011 Read latency SHALL be one cycle: the edge that ends a grant cycle registers rdata and asserts the matching rvalid for exactly one cycle.
REQ-012 If the granted address is >= AMOUNT, mem_rd SHALL be ignored, rdata SHALL register 0, and oob SHALL register 1; otherwise oob SHALL register 0.
REQ-013 When no grant occurs, rdata and oob SHALL hold their previous values and both rvalid outputs SHALL be 0.
REQ-014 Back-to-back grants SHALL sustain one access per cycle with no bubble.
REQ-015 cnt0/cnt1 SHALL increment on each grant to the respective requester and saturate at 16'hFFFF.
REQ-016 The FSM SHALL contain state ARB, plus HOLD0 and HOLD1 when the Configuration feature is compiled in; without that feature it SHALL remain in ARB.

Reset
REQ-017 While rst=1: prio=0, FSM=ARB, rdata=0, oob=0, rvalid0=rvalid1=0, cnt0=cnt1=0; gnt0, gnt1, and mem_a SHALL be 0 regardless of req.
REQ-018 Reset asserted mid-access SHALL discard the pending read; no rvalid SHALL follow reset deassertion unless a new grant occurs.

Configuration
REQ-019 Macro SEN_ARB_LOCK_EN, when defined, SHALL add input ports lock0 and lock1 (1 bit each).
REQ-020 With SEN_ARB_LOCK_EN defined:
  - a grant to requester n with lockn=1 SHALL move the FSM from ARB to HOLDn;
  - in HOLDn, only requester n SHALL be grantable, and prio SHALL not change;
  - the FSM SHALL return to ARB on the first cycle in which lockn=0 or reqn=0.
REQ-021 With SEN_ARB_LOCK_EN undefined, the lock ports SHALL be absent and behaviour SHALL be pure round-robin.

Verification
REQ-022 Reset, then req0=1, addr0=5, ROM word 5 = 24'h00A1B2 -> gnt0 high the same cycle; next cycle rvalid0=1, rdata=24'h00A1B2, oob=0.
REQ-023 req0=req1=1 held for 4 cycles from reset -> grant order 0,1,0,1; cnt0=2, cnt1=2; rvalid alternates accordingly.
REQ-024 req1=1, addr1=302 -> gnt1 high; next cycle rdata=0, oob=1, rvalid1=1.
REQ-025 Grant to requester 0 on cycle N, rst pulsed during cycle N -> no rvalid0 after reset; all outputs at reset values.
REQ-026 Drive 70000 grants to requester 0 -> cnt0 saturates at 16'hFFFF.
REQ-027 With SEN_ARB_LOCK_EN defined: lock0=1 with both requesters active for 3 cycles -> gnt0 on all 3 cycles; lock0 dropped -> next cycle grants requester 1.
